// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/settle/hold sequencer for a registered 16-bit ALU
// Define ALU_SEQ_DIV0_CHECK_EN to reject opcode 3 with B==0 instead of issuing it.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [DATA_W-1:0] CMD_A,
  input  logic [DATA_W-1:0] CMD_B,
  input  logic [3:0]        CMD_FUN,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [3:0]        ALU_FUN,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [4:0]        ALU_FLAGS,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [4:0]        RSP_FLAGS,
  output logic              RSP_ERR,
  output logic              BUSY
);

  localparam int unsigned    ENT_W   = 2 * DATA_W + 4;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, HOLD} state_t;

  state_t            state_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q, count, count_d;
  logic              ready_q, ready_d;
  logic              empty, push, pop, reject;
  logic [DATA_W-1:0] head_a, head_b;
  logic [3:0]        head_fun;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [3:0]        alu_fun_q;
  logic [4:0]        rsp_flags_q;
  logic              rsp_valid_q;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign push    = CMD_VALID & ready_q;
  assign pop     = !empty && ((state_q == IDLE) || ((state_q == HOLD) && RSP_READY));
  assign count_d = count + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);
  assign ready_d = (count_d != DEPTH_C);

  assign {head_a, head_b, head_fun} = mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef ALU_SEQ_DIV0_CHECK_EN
  logic rsp_err_q;
  assign reject  = (head_fun == 4'd3) && (head_b == '0);
  assign RSP_ERR = rsp_err_q;
`else
  assign reject  = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {CMD_A, CMD_B, CMD_FUN};
    end
  end

  // Ready is registered from the post-edge occupancy so it stays low through reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= 4'hF;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE:   state_q <= IDLE;
        ISSUE:  state_q <= SETTLE;
        SETTLE: begin
          // Carry is only refreshed by add/sub; anything else would report a stale value.
          rsp_data_q  <= ALU_OUT;
          rsp_flags_q <= {ALU_FLAGS[4] & (alu_fun_q[3:1] == 3'b000), ALU_FLAGS[3:0]};
          rsp_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
`ifdef ALU_SEQ_DIV0_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase

      if (pop && !reject) begin
        alu_a_q   <= head_a;
        alu_b_q   <= head_b;
        alu_fun_q <= head_fun;
        state_q   <= ISSUE;
      end
`ifdef ALU_SEQ_DIV0_CHECK_EN
      if (pop && reject) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= '1;
        rsp_flags_q <= 5'b01000;
        rsp_err_q   <= 1'b1;
        state_q     <= HOLD;
      end
`endif
    end
  end

  assign CMD_READY = ready_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_FLAGS = rsp_flags_q;
  assign BUSY      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a registered ALU stand-in
// Follows ALU_SEQ_DIV0_CHECK_EN the same way the design does.
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_A = '0, CMD_B = '0;
  logic [3:0]  CMD_FUN = '0;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic [3:0]  ALU_FUN;
  logic [4:0]  ALU_FLAGS;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [15:0] RSP_DATA;
  logic [4:0]  RSP_FLAGS;
  logic        RSP_ERR, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_FLAGS(RSP_FLAGS),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Registered ALU; its carry flag only moves on add/sub.
  logic [15:0] alu_out_q = '0;
  logic [4:0]  alu_flags_q = '0;
  assign ALU_OUT   = alu_out_q;
  assign ALU_FLAGS = alu_flags_q;

  always @(posedge CLK) begin
    logic [16:0] w;
    logic [15:0] r;
    w = '0;
    r = '0;
    case (ALU_FUN)
      4'd0: begin w = {1'b0, ALU_A} + {1'b0, ALU_B}; r = w[15:0]; alu_flags_q[4] <= w[16]; end
      4'd1: begin w = {1'b0, ALU_A} - {1'b0, ALU_B}; r = w[15:0]; alu_flags_q[4] <= w[16]; end
      4'd2: r = ALU_A * ALU_B;
      4'd3: r = (ALU_B == '0) ? 16'hFFFF : ALU_A / ALU_B;
      4'd4: r = ALU_A & ALU_B;
      4'd5: r = ALU_A | ALU_B;
      4'd6: r = ~(ALU_A & ALU_B);
      4'd7: r = ~(ALU_A | ALU_B);
      4'd8: r = ALU_A ^ ALU_B;
      4'd9: r = ~(ALU_A ^ ALU_B);
      4'd10: r = {15'd0, ALU_A == ALU_B};
      4'd11: r = {15'd0, ALU_A > ALU_B};
      4'd12: r = {15'd0, ALU_A < ALU_B};
      4'd13: r = ALU_A >> 1;
      4'd14: r = ALU_A << 1;
      default: r = '0;
    endcase
    alu_out_q      <= r;
    alu_flags_q[3] <= (ALU_FUN <= 4'd3);
    alu_flags_q[2] <= (ALU_FUN >= 4'd4) && (ALU_FUN <= 4'd9);
    alu_flags_q[1] <= (ALU_FUN >= 4'd10) && (ALU_FUN <= 4'd12);
    alu_flags_q[0] <= (ALU_FUN == 4'd13) || (ALU_FUN == 4'd14);
  end

  // Expected response {err, flags, data} for one command, from plain integer arithmetic.
  function automatic logic [21:0] model_rsp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int unsigned ua, ub, r;
    logic        c;
    logic [4:0]  fl;
    ua = a;
    ub = b;
    r  = 0;
    c  = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
    if (f == 4'd3 && b == 16'd0) return {1'b1, 5'b01000, 16'hFFFF};
`endif
    case (f)
      4'd0: begin r = ua + ub; c = (r > 65535); end
      4'd1: begin r = ua + 65536 - ub; c = (ua < ub); end
      4'd2: r = ua * ub;
      4'd3: r = (ub == 0) ? 65535 : ua / ub;
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ~(ua & ub);
      4'd7: r = ~(ua | ub);
      4'd8: r = ua ^ ub;
      4'd9: r = ~(ua ^ ub);
      4'd10: r = (ua == ub) ? 1 : 0;
      4'd11: r = (ua > ub) ? 1 : 0;
      4'd12: r = (ua < ub) ? 1 : 0;
      4'd13: r = ua / 2;
      4'd14: r = ua * 2;
      default: r = 0;
    endcase
    fl = {c, f <= 4'd3, (f >= 4'd4) && (f <= 4'd9), (f >= 4'd10) && (f <= 4'd12), (f == 4'd13) || (f == 4'd14)};
    return {1'b0, fl, r[15:0]};
  endfunction

  // Scoreboard: accepted commands enqueue a prediction, every valid response cycle is compared.
  logic [21:0] exp_q[$];
  int rsp_seen = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      exp_q.delete();
    end else begin
      if (RSP_VALID) begin
        rsp_seen++;
        chk("sb_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("sb_data",  32'(RSP_DATA),  32'(exp_q[0][15:0]));
          chk("sb_flags", 32'(RSP_FLAGS), 32'(exp_q[0][20:16]));
          chk("sb_err",   32'(RSP_ERR),   32'(exp_q[0][21]));
          if (RSP_READY) void'(exp_q.pop_front());
        end
      end
      if (CMD_VALID && CMD_READY) exp_q.push_back(model_rsp(CMD_A, CMD_B, CMD_FUN));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    bit done;
    done = 1'b0;
    CMD_A = a; CMD_B = b; CMD_FUN = f; CMD_VALID = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        step();
        done = 1'b1;
      end
    end
    CMD_VALID = 1'b0;
    chk("push_accepted", 32'(done), 1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 60 && !RSP_VALID; i++) step();
    chk(tag, 32'(RSP_VALID), 1);
  endtask

  logic [15:0] fill_data  [5] = '{16'h0000, 16'h0FF0, 16'h0FF0, 16'h0078, 16'h01E0};
  logic [4:0]  fill_flags [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00001, 5'b00001};
  logic [3:0]  fill_fun   [5] = '{4'd4, 4'd5, 4'd8, 4'd13, 4'd14};

  initial begin
    int seen0;

    #12;
    chk("rst_cmd_ready", 32'(CMD_READY), 0);
    chk("rst_alu_a",     32'(ALU_A), 0);
    chk("rst_alu_b",     32'(ALU_B), 0);
    chk("rst_alu_fun",   32'(ALU_FUN), 'hF);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rsp_data",  32'(RSP_DATA), 0);
    chk("rst_rsp_flags", 32'(RSP_FLAGS), 0);
    chk("rst_rsp_err",   32'(RSP_ERR), 0);
    chk("rst_busy",      32'(BUSY), 0);
    step();
    RST = 1'b1;
    step();
    chk("ready_after_rst", 32'(CMD_READY), 1);

    // Latency: response valid on the fourth edge counting the accepting edge.
    RSP_READY = 1'b1;
    push(16'h0003, 16'h0004, 4'd0);
    chk("lat_e1", 32'(RSP_VALID), 0);
    step();
    chk("lat_e2", 32'(RSP_VALID), 0);
    step();
    chk("lat_e3", 32'(RSP_VALID), 0);
    step();
    chk("lat_e4", 32'(RSP_VALID), 1);
    chk("add_data", 32'(RSP_DATA), 'h0007);
    chk("add_flags", 32'(RSP_FLAGS), 'b01000);
    step();
    chk("add_valid_clr", 32'(RSP_VALID), 0);
    chk("add_busy_clr", 32'(BUSY), 0);

    push(16'hFFFF, 16'h0001, 4'd0);
    wait_rsp("carry_rsp");
    chk("carry_data", 32'(RSP_DATA), 'h0000);
    chk("carry_flags", 32'(RSP_FLAGS), 'b11000);
    step();

    push(16'h0010, 16'h0000, 4'd3);
    wait_rsp("div0_rsp");
    chk("div0_data", 32'(RSP_DATA), 'hFFFF);
    chk("div0_flags", 32'(RSP_FLAGS), 'b01000);
`ifdef ALU_SEQ_DIV0_CHECK_EN
    chk("div0_err", 32'(RSP_ERR), 1);
    chk("div0_fun_kept", 32'(ALU_FUN), 0);
    chk("div0_a_kept", 32'(ALU_A), 'hFFFF);
`else
    chk("div0_err", 32'(RSP_ERR), 0);
    chk("div0_fun_issued", 32'(ALU_FUN), 3);
    chk("div0_a_issued", 32'(ALU_A), 'h0010);
`endif
    step();
    push(16'h0010, 16'h0002, 4'd3);
    wait_rsp("div_rsp");
    chk("div_data", 32'(RSP_DATA), 'h0008);
    chk("div_err", 32'(RSP_ERR), 0);
    chk("div_fun", 32'(ALU_FUN), 3);
    step();

    // Fill while the first result stalls in HOLD; the carry flag in the ALU is stale from the earlier add.
    RSP_READY = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h00F0, 16'h0F00, fill_fun[i]);
    CMD_A = 16'h0001; CMD_B = 16'h0001; CMD_FUN = 4'd0; CMD_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_not_ready", 32'(CMD_READY), 0);
      step();
    end
    CMD_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(RSP_VALID), 1);
      chk("hold_data",  32'(RSP_DATA), 'h0000);
      chk("hold_flags", 32'(RSP_FLAGS), 'b00100);
      chk("hold_alu_a", 32'(ALU_A), 'h00F0);
      chk("hold_alu_b", 32'(ALU_B), 'h0F00);
      chk("hold_fun",   32'(ALU_FUN), 4);
      step();
    end
    RSP_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp("fill_rsp");
      chk("fill_data", 32'(RSP_DATA), 32'(fill_data[i]));
      chk("fill_flags", 32'(RSP_FLAGS), 32'(fill_flags[i]));
      step();
    end
    step();
    chk("fill_busy_clr", 32'(BUSY), 0);

    // Reset while the first command settles and two more are queued.
    push(16'h0005, 16'h0006, 4'd2);
    push(16'h0007, 16'h0008, 4'd1);
    push(16'h0009, 16'h000A, 4'd4);
    chk("mid_busy", 32'(BUSY), 1);
    chk("mid_alu_a", 32'(ALU_A), 'h0005);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(RSP_VALID), 0);
    chk("async_alu_a", 32'(ALU_A), 0);
    chk("async_alu_fun", 32'(ALU_FUN), 'hF);
    chk("async_busy", 32'(BUSY), 0);
    chk("async_ready", 32'(CMD_READY), 0);
    step();
    step();
    RST = 1'b1;
    seen0 = rsp_seen;
    for (int i = 0; i < 12; i++) step();
    chk("no_rsp_after_rst", 32'(rsp_seen - seen0), 0);
    chk("idle_after_rst", 32'(BUSY), 0);
    push(16'h1234, 16'h1111, 4'd1);
    wait_rsp("recover_rsp");
    chk("recover_data", 32'(RSP_DATA), 'h0123);
    step();

    // Randomized traffic with backpressure, scored by the monitor.
    for (int cyc = 0; cyc < 500; cyc++) begin
      CMD_VALID = ($urandom_range(0, 2) != 0);
      CMD_A     = 16'($urandom);
      CMD_B     = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      CMD_FUN   = 4'($urandom_range(0, 15));
      RSP_READY = ($urandom_range(0, 3) != 0);
      step();
    end
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 0);
    chk("drain_busy", 32'(BUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
